// File: rtl/bnnseq_test_driver_if.sv
// Result handshake between the BNN test driver and whatever consumes its per-sample results.
interface bnnseq_test_driver_if #(
  parameter int IDX_W = 10,
  parameter int CLS_W = 2
);
  logic             res_valid;
  logic             res_ready;
  logic [IDX_W-1:0] res_index;
  logic [CLS_W-1:0] res_class;

  modport master (output res_valid, res_index, res_class, input res_ready);
  modport slave  (input res_valid, res_index, res_class, output res_ready);
endinterface

// File: rtl/bnnseq_test_driver.sv
// Walks a test ROM through a sequential BNN and emits one classified result per sample.
// Latency: FEAT_CNT+HIDDEN_CNT+3 cycles per sample with res_ready high.
// Backpressure: EMIT holds res_valid/res_index/res_class until res_ready is sampled high.
module bnnseq_test_driver #(
  parameter int FEAT_CNT   = 19,
  parameter int HIDDEN_CNT = 40,
  parameter int FEAT_BITS  = 4,
  parameter int CLASS_CNT  = 3,
  parameter int TEST_CNT   = 1000,
  localparam int IDX_W    = $clog2(TEST_CNT),
  localparam int CLS_W    = $clog2(CLASS_CNT),
  localparam int CNT_W    = $clog2(TEST_CNT + 1),
  localparam int SMP_W    = FEAT_BITS * FEAT_CNT,
  localparam int WAIT_CYC = FEAT_CNT + HIDDEN_CNT,
  localparam int WAIT_W   = $clog2(WAIT_CYC + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic [IDX_W-1:0]           mem_addr,
  output logic                       mem_en,
  input  logic [SMP_W-1:0]           mem_data,
  output logic [SMP_W-1:0]           features,
  output logic                       bnn_rst,
  input  logic [CLS_W-1:0]           prediction,
  bnnseq_test_driver_if.master       res,
  output logic [CLASS_CNT*CNT_W-1:0] class_hist,
  output logic [CNT_W-1:0]           bad_cnt,
  output logic                       busy,
  output logic                       done
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_RUN, S_EMIT, S_DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] index;
  logic [WAIT_W-1:0] cnt;
  logic [CLS_W-1:0] class_q;
  logic             valid_q;
  logic [CNT_W-1:0] hist_q [CLASS_CNT];

  assign mem_addr      = index;
  assign res.res_valid = valid_q;
  assign res.res_index = index;
  assign res.res_class = class_q;

  for (genvar c = 0; c < CLASS_CNT; c++) begin : g_hist
    assign class_hist[c*CNT_W +: CNT_W] = hist_q[c];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      index    <= '0;
      cnt      <= '0;
      features <= '0;
      class_q  <= '0;
      for (int c = 0; c < CLASS_CNT; c++) hist_q[c] <= '0;
      bad_cnt  <= '0;
      valid_q  <= 1'b0;
      mem_en   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bnn_rst  <= 1'b1;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state   <= S_FETCH;
            index   <= '0;
            for (int c = 0; c < CLASS_CNT; c++) hist_q[c] <= '0;
            bad_cnt <= '0;
            mem_en  <= 1'b1;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        S_FETCH: begin
          state  <= S_LOAD;
          mem_en <= 1'b0;
        end
        S_LOAD: begin
          // ROM data is valid this cycle; BNN leaves reset with a stable sample.
          state    <= S_RUN;
          features <= mem_data;
          bnn_rst  <= 1'b0;
          cnt      <= '0;
        end
        S_RUN: begin
          if (cnt == WAIT_W'(WAIT_CYC - 1)) begin
            state   <= S_EMIT;
            class_q <= prediction;
            bnn_rst <= 1'b1;
            valid_q <= 1'b1;
            if (int'(prediction) < CLASS_CNT) begin
              if (hist_q[prediction] != CNT_W'(TEST_CNT))
                hist_q[prediction] <= hist_q[prediction] + 1'b1;
            end else if (bad_cnt != CNT_W'(TEST_CNT)) begin
              bad_cnt <= bad_cnt + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_EMIT: begin
          if (res.res_ready) begin
            valid_q <= 1'b0;
            if (index == IDX_W'(TEST_CNT - 1)) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state  <= S_FETCH;
              index  <= index + 1'b1;
              mem_en <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bnnseq_test_driver.sv
// Directed/randomized bench for bnnseq_test_driver with a ROM model and a timed BNN stand-in.
module tb_bnnseq_test_driver;
  localparam int FEAT_CNT   = 19;
  localparam int HIDDEN_CNT = 40;
  localparam int FEAT_BITS  = 4;
  localparam int CLASS_CNT  = 3;
  localparam int TEST_CNT   = 3;
  localparam int WAIT_CYC   = FEAT_CNT + HIDDEN_CNT;
  localparam int IDX_W      = $clog2(TEST_CNT);
  localparam int CLS_W      = $clog2(CLASS_CNT);
  localparam int CNT_W      = $clog2(TEST_CNT + 1);
  localparam int SMP_W      = FEAT_BITS * FEAT_CNT;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       start;
  logic [IDX_W-1:0]           mem_addr;
  logic                       mem_en;
  logic [SMP_W-1:0]           mem_data;
  logic [SMP_W-1:0]           features;
  logic                       bnn_rst;
  logic [CLS_W-1:0]           prediction;
  logic [CLASS_CNT*CNT_W-1:0] class_hist;
  logic [CNT_W-1:0]           bad_cnt;
  logic                       busy;
  logic                       done;

  bnnseq_test_driver_if #(.IDX_W(IDX_W), .CLS_W(CLS_W)) res ();

  bnnseq_test_driver #(
    .FEAT_CNT(FEAT_CNT), .HIDDEN_CNT(HIDDEN_CNT), .FEAT_BITS(FEAT_BITS),
    .CLASS_CNT(CLASS_CNT), .TEST_CNT(TEST_CNT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mem_addr(mem_addr), .mem_en(mem_en),
    .mem_data(mem_data), .features(features), .bnn_rst(bnn_rst), .prediction(prediction),
    .res(res), .class_hist(class_hist), .bad_cnt(bad_cnt), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Test ROM with one-cycle read latency, and a BNN stand-in whose answer is only
  // correct in the last cycle of a full WAIT_CYC-long run (class = low feature bits).
  logic [SMP_W-1:0] rom [TEST_CNT];
  int cls_tab [TEST_CNT];
  int run_cyc = 0;
  int cyc = 0;
  always @(posedge clk) if (mem_en) mem_data <= rom[mem_addr];
  always @(posedge clk) run_cyc <= bnn_rst ? 0 : run_cyc + 1;
  always @(posedge clk) cyc <= cyc + 1;
  assign prediction = (run_cyc == WAIT_CYC - 1) ? features[CLS_W-1:0] : ~features[CLS_W-1:0];

  int n_vec = 0;
  int n_err = 0;
  int prev_t;

  task automatic chk(input string tag, input logic [SMP_W-1:0] obs, input logic [SMP_W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_rom(input bit random_cls);
    for (int i = 0; i < TEST_CNT; i++) begin
      logic [SMP_W-1:0] w;
      for (int j = 0; j < FEAT_CNT; j++) w[j*FEAT_BITS +: FEAT_BITS] = FEAT_BITS'($urandom_range(0, 15));
      cls_tab[i] = random_cls ? ((i == 1) ? 3 : int'($urandom_range(0, 3))) : i;
      w[CLS_W-1:0] = CLS_W'(cls_tab[i]);
      rom[i] = w;
    end
  endtask

  task automatic chk_totals(input string tag);
    int h [CLASS_CNT];
    int bad;
    bad = 0;
    for (int c = 0; c < CLASS_CNT; c++) h[c] = 0;
    for (int i = 0; i < TEST_CNT; i++)
      if (cls_tab[i] < CLASS_CNT) h[cls_tab[i]]++; else bad++;
    for (int c = 0; c < CLASS_CNT; c++)
      chk($sformatf("%s_hist%0d", tag, c), class_hist[c*CNT_W +: CNT_W], h[c]);
    chk({tag, "_bad"}, bad_cnt, bad);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_bnnrst"}, bnn_rst, 1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_bnnrst"}, bnn_rst, 1);
    chk({tag, "_memen"}, mem_en, 0);
    chk({tag, "_vld"}, res.res_valid, 0);
    chk({tag, "_idx"}, res.res_index, 0);
    chk({tag, "_cls"}, res.res_class, 0);
    chk({tag, "_feat"}, features, 0);
    chk({tag, "_hist"}, class_hist, 0);
    chk({tag, "_bad"}, bad_cnt, 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Entered at the FETCH negedge of sample i; leaves at the negedge after the transfer.
  task automatic run_sample(input int i, input int hold, input bit poke);
    int t0;
    int n;
    t0 = cyc;
    res.res_ready = (hold == 0);
    chk("fetch_en", mem_en, 1);
    chk("fetch_addr", mem_addr, i);
    chk("fetch_busy", busy, 1);
    chk("fetch_bnnrst", bnn_rst, 1);
    @(negedge clk);
    chk("load_bnnrst", bnn_rst, 1);
    @(negedge clk);
    chk("features", features, rom[i]);
    n = 0;
    while (bnn_rst === 1'b0 && n < 4 * WAIT_CYC) begin
      start = (poke && n == 10);
      n++;
      @(negedge clk);
    end
    start = 1'b0;
    chk("run_len", n, WAIT_CYC);
    chk("emit_lat", cyc - t0, WAIT_CYC + 2);
    chk("emit_vld", res.res_valid, 1);
    chk("emit_idx", res.res_index, i);
    chk("emit_cls", res.res_class, cls_tab[i]);
    chk("emit_feat", features, rom[i]);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("hold_vld", res.res_valid, 1);
      chk("hold_idx", res.res_index, i);
      chk("hold_cls", res.res_class, cls_tab[i]);
      chk("hold_bnnrst", bnn_rst, 1);
    end
    res.res_ready = 1'b1;
    @(negedge clk);
    chk("post_vld", res.res_valid, 0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    start = 1'b0;
    res.res_ready = 1'b1;
    mem_data = '0;
    fill_rom(1'b0);
    repeat (3) @(negedge clk);
    chk_reset("rst0");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_memen", mem_en, 0);

    // Class equals sample index, ready tied high: back-to-back 62-cycle spacing.
    pulse_start();
    for (int i = 0; i < TEST_CNT; i++) begin
      if (i > 0) chk("spacing", cyc - prev_t, WAIT_CYC + 3);
      prev_t = cyc;
      run_sample(i, 0, 1'b0);
    end
    chk_totals("runA");
    repeat (4) @(negedge clk);
    chk_totals("runA_hold");

    // Restart from DONE with random classes (sample 1 out of range), backpressure, stray start.
    fill_rom(1'b1);
    pulse_start();
    chk("restart_hist", class_hist, 0);
    chk("restart_bad", bad_cnt, 0);
    chk("restart_addr", mem_addr, 0);
    run_sample(0, 5, 1'b0);
    run_sample(1, $urandom_range(0, 3), 1'b1);
    run_sample(2, $urandom_range(0, 2), 1'b0);
    chk_totals("runB");

    // Reset in RUN cycle 30 of sample 1, after sample 0 was counted.
    fill_rom(1'b1);
    pulse_start();
    run_sample(0, 0, 1'b0);
    repeat (32) @(negedge clk);
    chk("c_in_run", bnn_rst, 0);
    #2 rst = 1'b1;
    #1 chk_reset("rstC");
    @(negedge clk);
    rst = 1'b0;

    // Reset while a result is stalled in EMIT: valid drops at once, nothing counted.
    pulse_start();
    chk("d_addr", mem_addr, 0);
    res.res_ready = 1'b0;
    n = 0;
    while (res.res_valid !== 1'b1 && n < 4 * WAIT_CYC) begin
      n++;
      @(negedge clk);
    end
    chk("d_emit", res.res_valid, 1);
    #2 rst = 1'b1;
    #1 chk_reset("rstD");
    @(negedge clk);
    rst = 1'b0;
    res.res_ready = 1'b1;
    @(negedge clk);

    // Fresh random run after the aborted ones.
    fill_rom(1'b1);
    pulse_start();
    for (int i = 0; i < TEST_CNT; i++) run_sample(i, $urandom_range(0, 1), 1'b0);
    chk_totals("runE");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/bnnseq_test_driver.md
BNNSEQ_TEST_DRIVER -- requirements
Module: bnnseq_test_driver

Interface
REQ-001 SHALL have parameter FEAT_CNT, default 19, number of features per sample.
REQ-002 SHALL have parameter HIDDEN_CNT, default 40, hidden neurons in the driven sequential BNN.
REQ-003 SHALL have parameter FEAT_BITS, default 4, bits per feature.
REQ-004 SHALL have parameter CLASS_CNT, default 3, number of classes.
REQ-005 SHALL have parameter TEST_CNT, default 1000, number of samples in the test memory.
REQ-006 SHALL have one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 start  in  1  begin a run from sample 0; accepted only in IDLE or DONE.
REQ-009 mem_addr  out  clog2(TEST_CNT)  sample index to the test ROM.
REQ-010 mem_en  out  1  ROM read enable; the ROM returns mem_data one cycle after mem_en.
REQ-011 mem_data  in  FEAT_BITS*FEAT_CNT  packed sample from the ROM.
REQ-012 features  out  FEAT_BITS*FEAT_CNT  sample driven to the BNN features port.
REQ-013 bnn_rst  out  1  active-high reset driven to the BNN.
REQ-014 prediction  in  clog2(CLASS_CNT)  BNN class output.
REQ-015 res_valid / res_ready  out / in  1 each  result handshake.
REQ-016 res_index  out  clog2(TEST_CNT)  sample index of the current result.
REQ-017 res_class  out  clog2(CLASS_CNT)  captured prediction.
REQ-018 class_hist  out  CLASS_CNT*clog2(TEST_CNT+1)  per-class counts, class 0 in the LSBs.
REQ-019 bad_cnt  out  clog2(TEST_CNT+1)  count of predictions >= CLASS_CNT.
REQ-020 busy, done  out  1 each  run in progress; run complete.

Function
REQ-021 FSM states SHALL be IDLE, FETCH, LOAD, RUN, EMIT, DONE.
REQ-022 IDLE/DONE + start -> FETCH, with the index, class_hist and bad_cnt cleared to 0; without start, the FSM stays in its state.
REQ-023 FETCH (1 cycle): mem_en=1, mem_addr=index -> LOAD.
REQ-024 LOAD (1 cycle): features<=mem_data registered on exit, bnn_rst=1 -> RUN.
REQ-025 RUN: bnn_rst=0 for exactly WAIT_CYC=FEAT_CNT+HIDDEN_CNT cycles (59 at defaults); on the edge ending the last RUN cycle, res_class<=prediction -> EMIT.
REQ-026 Histogram update on that same edge: class_hist[prediction]+1 if prediction<CLASS_CNT, else bad_cnt+1; counters saturate at TEST_CNT.
REQ-027 EMIT: res_valid=1 with res_index and res_class stable until res_ready is sampled high; res_valid=0 in all other states.
REQ-028 EMIT + res_ready: if index==TEST_CNT-1 -> DONE, else index+1 and -> FETCH.
REQ-029 A transfer SHALL complete in the first EMIT cycle if res_ready is already high (no bubble).
REQ-030 Per-sample latency with res_ready tied high SHALL be WAIT_CYC+3 cycles (62 at defaults).
REQ-031 features SHALL hold its value from LOAD exit through EMIT; the BNN sees a stable sample for the whole RUN.
REQ-032 busy=1 in FETCH/LOAD/RUN/EMIT; done=1 only in DONE; start in other states SHALL be ignored.
REQ-033 bnn_rst SHALL be 1 in IDLE, FETCH, LOAD, EMIT and DONE, so the BNN is held in reset outside RUN.
REQ-034 Histogram outputs SHALL hold their final values in DONE until the next accepted start.

Reset
REQ-035 rst SHALL asynchronously force IDLE, index=0, features=0, res_class=0, class_hist=0, bad_cnt=0, res_valid=0, mem_en=0, busy=0, done=0 and bnn_rst=1.
REQ-036 rst asserted mid-RUN or mid-EMIT SHALL abort the run, drop res_valid the same cycle, and not count the pending result.

Verification
REQ-037 TEST_CNT=3, ROM patterns, model returning class=index, res_ready=1 -> results (0,0),(1,1),(2,2) at 62-cycle spacing; class_hist=1,1,1; done=1.
REQ-038 res_ready low for 5 cycles in EMIT -> res_valid, res_index and res_class held; the FSM advances only after the ready cycle; bnn_rst stays 1.
REQ-039 model returns 3 (CLASS_CNT=3) for one sample -> bad_cnt=1; that sample is not counted in class_hist.
REQ-040 rst pulsed in RUN cycle 30 -> all outputs return to reset values; a new start restarts at index 0.
REQ-041 start pulsed while busy -> ignored; in DONE -> counters cleared and the run restarts with mem_addr=0.
REQ-042 bench checks bnn_rst=0 for exactly 59 consecutive cycles per sample and mem_data captured into features one cycle after mem_en.
